// File: rtl/add_seq_ctrl.sv
// Serial limb adder/subtractor: one 5-bit limb per clock through a shared adder,
// with a registered inter-limb carry and a small IDLE/ADD/DONE sequencer.
//
// state | meaning
// IDLE  | ready; operands and carry seed captured on start_in
// ADD   | one limb per edge, LSB first; top limb updates carry_out/overflow
// DONE  | one-cycle done_out pulse, then back to IDLE
module add_seq_ctrl #(
  parameter int NUM_LIMBS = 4,
  localparam int W = 5 * NUM_LIMBS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_in,
  input  logic         sub_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         carry_in,
  output logic         ready_out,
  output logic         busy_out,
  output logic         done_out,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow
);

  localparam int IDX_W = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q;
  logic               sub_q;
  logic               carry_q;
  logic [IDX_W-1:0]   limb_idx;
  logic [4:0]         a_limb, b_limb, b_eff;
  logic [5:0]         limb_sum;
  logic               top_cin;
  logic               is_top;

  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int i = 0; i < NUM_LIMBS; i++) begin
      if (limb_idx == IDX_W'(i)) begin
        a_limb = a_q[5*i +: 5];
        b_limb = b_q[5*i +: 5];
      end
    end
    b_eff    = sub_q ? ~b_limb : b_limb;
    limb_sum = {1'b0, a_limb} + {1'b0, b_eff} + {5'd0, carry_q};
    // carry into the MSB of this limb, recovered from its sum bit
    top_cin  = a_limb[4] ^ b_eff[4] ^ limb_sum[4];
    is_top   = (limb_idx == IDX_W'(NUM_LIMBS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_in) state_d = ADD;
      ADD:     if (is_top)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready_out = (state_q == IDLE);
  assign busy_out  = ~ready_out;
  assign done_out  = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      limb_idx  <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            a_q      <= a_in;
            b_q      <= b_in;
            sub_q    <= sub_in;
            // subtract is a + ~b + 1, so the seed carry is forced high
            carry_q  <= sub_in ? 1'b1 : carry_in;
            limb_idx <= '0;
          end
        end
        ADD: begin
          for (int i = 0; i < NUM_LIMBS; i++) begin
            if (limb_idx == IDX_W'(i)) result[5*i +: 5] <= limb_sum[4:0];
          end
          carry_q  <= limb_sum[5];
          limb_idx <= limb_idx + IDX_W'(1);
          if (is_top) begin
            carry_out <= limb_sum[5];
            overflow  <= top_cin ^ limb_sum[5];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl (default NUM_LIMBS=4, W=20) with
// hand-computed expected results, latency and throughput.
module tb_add_seq_ctrl;

  localparam int NL = 4;
  localparam int W  = 5 * NL;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_in;
  logic         sub_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         carry_in;
  logic         ready_out;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  add_seq_ctrl #(.NUM_LIMBS(NL)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_in  (start_in),
    .sub_in    (sub_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .carry_in  (carry_in),
    .ready_out (ready_out),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_out && n < 20) begin
      tick();
      n++;
    end
    if (!done_out) check("done_timeout", 32'(done_out), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input logic [W-1:0] er,
                        input logic eco, input logic eov);
    int n;
    a_in = a; b_in = b; sub_in = sub; carry_in = cin; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_done(n);
    check({tag, "_lat"}, 32'(n), 32'(NL));
    check({tag, "_res"}, 32'(result), 32'(er));
    check({tag, "_co"},  32'(carry_out), 32'(eco));
    check({tag, "_ov"},  32'(overflow), 32'(eov));
    tick();
    check({tag, "_pulse"}, 32'(done_out), 32'd0);
    check({tag, "_rdy"},   32'(ready_out), 32'd1);
  endtask

  initial begin
    int n, t1, t2, dones;
    reset = 1'b1; start_in = 1'b1; sub_in = 1'b0; a_in = '1; b_in = '1; carry_in = 1'b1;
    tick(); tick();
    check("rst_res",  32'(result), 32'd0);
    check("rst_co",   32'(carry_out), 32'd0);
    check("rst_ov",   32'(overflow), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_rdy",  32'(ready_out), 32'd1);
    start_in = 1'b0;
    reset = 1'b0;
    tick();
    check("post_rst_rdy",  32'(ready_out), 32'd1);
    check("post_rst_busy", 32'(busy_out), 32'd0);

    run_op("add_basic",  20'h00001, 20'h00001, 1'b0, 1'b0, 20'h00002, 1'b0, 1'b0);
    run_op("ripple",     20'hFFFFF, 20'h00000, 1'b0, 1'b1, 20'h00000, 1'b1, 1'b0);
    run_op("sgn_ovf",    20'h7FFFF, 20'h00001, 1'b0, 1'b0, 20'h80000, 1'b0, 1'b1);
    run_op("sub_borrow", 20'h00005, 20'h00007, 1'b1, 1'b1, 20'hFFFFE, 1'b0, 1'b0);
    run_op("sub_ok",     20'h00007, 20'h00005, 1'b1, 1'b0, 20'h00002, 1'b1, 1'b0);

    // start during ADD with new operands: ignored, operands already captured
    a_in = 20'h12345; b_in = 20'h11111; sub_in = 1'b0; carry_in = 1'b0; start_in = 1'b1;
    tick();
    a_in = 20'hFFFFF; b_in = 20'hAAAAA; sub_in = 1'b1; carry_in = 1'b1;
    tick();
    check("busy_busy", 32'(busy_out), 32'd1);
    check("busy_rdy",  32'(ready_out), 32'd0);
    tick();
    start_in = 1'b0;
    wait_done(n);
    check("busy_lat", 32'(n), 32'(NL - 2));
    check("busy_res", 32'(result), 32'h23456);
    check("busy_co",  32'(carry_out), 32'd0);
    tick();

    // start held high: one acceptance every NL+2 cycles
    a_in = 20'h00001; b_in = 20'h00002; sub_in = 1'b0; carry_in = 1'b0; start_in = 1'b1;
    wait_done(n);
    t1 = cyc;
    check("b2b_res1", 32'(result), 32'h00003);
    tick();
    wait_done(n);
    t2 = cyc;
    start_in = 1'b0;
    check("b2b_period", 32'(t2 - t1), 32'(NL + 2));
    check("b2b_res2", 32'(result), 32'h00003);
    tick();
    check("b2b_rdy", 32'(ready_out), 32'd1);

    run_op("sub_ovf", 20'h80000, 20'h00001, 1'b1, 1'b0, 20'h7FFFF, 1'b1, 1'b1);

    // reset on the 2nd ADD edge; flags must hold until the top limb
    a_in = 20'h00003; b_in = 20'h00004; sub_in = 1'b0; carry_in = 1'b0; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    tick();
    check("mid_res", 32'(result), 32'h7FFE7);
    check("mid_co",  32'(carry_out), 32'd1);
    check("mid_ov",  32'(overflow), 32'd1);
    reset = 1'b1;
    tick();
    check("mrst_res",  32'(result), 32'd0);
    check("mrst_co",   32'(carry_out), 32'd0);
    check("mrst_ov",   32'(overflow), 32'd0);
    check("mrst_done", 32'(done_out), 32'd0);
    reset = 1'b0;
    tick();
    check("mrst_rdy",  32'(ready_out), 32'd1);
    check("mrst_busy", 32'(busy_out), 32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_out) dones++;
      tick();
    end
    check("mrst_no_done", 32'(dones), 32'd0);
    run_op("after_rst", 20'h00010, 20'h00020, 1'b0, 1'b0, 20'h00030, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
